// File: rtl/pic_writer_if.sv
// Bus bundle between the frame controller / image memory and pic_writer.
// The slave modport is the writer's view; the master modport is the controller/memory side.
interface pic_writer_if;
  logic        start;
  logic [19:0] PIC_addr;
  logic [19:0] FB_addr;
  logic [2:0]  PIC_size;
  logic [23:0] IM_Q;
  logic [19:0] IM_A;
  logic [23:0] IM_D;
  logic        IM_WEN;
  logic        busy;
  logic        PIC_Write_Done;

  modport master (
    output start, PIC_addr, FB_addr, PIC_size, IM_Q,
    input  IM_A, IM_D, IM_WEN, busy, PIC_Write_Done
  );

  modport slave (
    input  start, PIC_addr, FB_addr, PIC_size, IM_Q,
    output IM_A, IM_D, IM_WEN, busy, PIC_Write_Done
  );
endinterface

// File: rtl/pic_writer.sv
// Copies a 128x128, 256x256 (2x2 box-averaged) or 512x512 (4x subsampled) picture
// into a 128x128 frame buffer region of the shared image memory.
module pic_writer (
  input  logic        clk,
  input  logic        reset,
  pic_writer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, WR, AVG0, AVG1, AVG2, AVG3, DONE} state_t;

  state_t      state_q, state_d;
  logic [6:0]  x_q, x_d, y_q, y_d;
  logic [19:0] picAddr_q, picAddr_d, fbAddr_q, fbAddr_d;
  logic [2:0]  size_q, size_d;
  logic [9:0]  accR_q, accR_d, accG_q, accG_d, accB_q, accB_d;

  logic [1:0]  sub;
  logic [19:0] srcSmall, srcLarge, srcMid, dstAddr;
  logic [23:0] avgPixel;

  function automatic logic [7:0] avgCh(input logic [9:0] acc, input logic [7:0] q);
    return 8'((acc + {2'b00, q}) >> 2);
  endfunction

  // Sub-pixel index inside the 2x2 block being read by the averaging states.
  always_comb begin
    sub = 2'd0;
    case (state_q)
      AVG1:    sub = 2'd1;
      AVG2:    sub = 2'd2;
      AVG3:    sub = 2'd3;
      default: sub = 2'd0;
    endcase
  end

  assign srcSmall = picAddr_q + {6'd0, y_q, x_q};
  assign srcLarge = picAddr_q + {2'd0, y_q, 11'd0} + {11'd0, x_q, 2'd0};
  assign srcMid   = picAddr_q + {4'd0, y_q, sub[1], x_q, sub[0]};
  assign dstAddr  = fbAddr_q + {6'd0, y_q, x_q};
  assign avgPixel = {avgCh(accR_q, bus.IM_Q[23:16]),
                     avgCh(accG_q, bus.IM_Q[15:8]),
                     avgCh(accB_q, bus.IM_Q[7:0])};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      picAddr_q <= '0;
      fbAddr_q  <= '0;
      size_q    <= '0;
      accR_q    <= '0;
      accG_q    <= '0;
      accB_q    <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      picAddr_q <= picAddr_d;
      fbAddr_q  <= fbAddr_d;
      size_q    <= size_d;
      accR_q    <= accR_d;
      accG_q    <= accG_d;
      accB_q    <= accB_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    x_d                = x_q;
    y_d                = y_q;
    picAddr_d          = picAddr_q;
    fbAddr_d           = fbAddr_q;
    size_d             = size_q;
    accR_d             = accR_q;
    accG_d             = accG_q;
    accB_d             = accB_q;
    bus.IM_A           = '0;
    bus.IM_D           = '0;
    bus.IM_WEN         = 1'b1;
    bus.busy           = (state_q != IDLE);
    bus.PIC_Write_Done = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          picAddr_d = bus.PIC_addr;
          fbAddr_d  = bus.FB_addr;
          size_d    = bus.PIC_size;
          x_d       = '0;
          y_d       = '0;
          case (bus.PIC_size)
            3'b001, 3'b100: state_d = RD;
            3'b010:         state_d = AVG0;
            default:        state_d = DONE;
          endcase
        end
      end
      RD: begin
        bus.IM_A = (size_q == 3'b100) ? srcLarge : srcSmall;
        state_d  = WR;
      end
      // Read data lags the address by a cycle, so AVG1..AVG3 fold in the previous read
      // and WR adds the last one on the fly.
      AVG0: begin
        bus.IM_A = srcMid;
        accR_d   = '0;
        accG_d   = '0;
        accB_d   = '0;
        state_d  = AVG1;
      end
      AVG1, AVG2, AVG3: begin
        bus.IM_A = srcMid;
        accR_d   = accR_q + {2'b00, bus.IM_Q[23:16]};
        accG_d   = accG_q + {2'b00, bus.IM_Q[15:8]};
        accB_d   = accB_q + {2'b00, bus.IM_Q[7:0]};
        if (state_q == AVG1)      state_d = AVG2;
        else if (state_q == AVG2) state_d = AVG3;
        else                      state_d = WR;
      end
      WR: begin
        bus.IM_WEN = 1'b0;
        bus.IM_A   = dstAddr;
        bus.IM_D   = (size_q == 3'b010) ? avgPixel : bus.IM_Q;
        if ({y_q, x_q} == 14'h3FFF) begin
          state_d = DONE;
        end else begin
          {y_d, x_d} = {y_q, x_q} + 14'd1;
          state_d    = (size_q == 3'b010) ? AVG0 : RD;
        end
      end
      DONE: begin
        bus.PIC_Write_Done = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
